rfdc_info_reader: RTL and testbench
===================================

// Module: rfdc_info_reader
//
// PURPOSE
//   Ctrlport master that walks the read-only RFDC info memory after a start pulse.
//   Reads NUM_ENTRIES 32-bit entries at BASE_ADDR + i*ADDR_STRIDE.
//   Emits each entry with its index on a valid/ready stream for downstream RFDC
//   config logic. Detects ctrlport error status and response timeout, and stops on the first fault.
//
// PARAMETERS
//   NUM_ENTRIES     16    number of entries to read (>=1)
//   BASE_ADDR       0     20-bit ctrlport byte address of entry 0
//   ADDR_STRIDE     4     byte address increment per entry
//   TIMEOUT_CYCLES  1024  max WAIT cycles for ack before a timeout fault (>=2)
//
// PORTS
//   clk                     in   1   single clock domain
//   rst                     in   1   synchronous, active-high reset
//   start                   in   1   begin a sweep (sampled only in IDLE/DONE/ERROR)
//   busy                    out  1   sweep in progress
//   done                    out  1   sticky: all entries read OK; cleared by start
//   error                   out  1   sticky: sweep aborted; cleared by start
//   err_timeout             out  1   1 = fault was a timeout, 0 = bad status
//   err_status              out  2   resp_status captured at fault (0 on timeout)
//   err_index               out  IW  entry index at fault; IW = max(1,$clog2(NUM_ENTRIES))
//   m_ctrlport_req_addr     out  20  request address
//   m_ctrlport_req_byte_en  out  4   always 4'hF
//   m_ctrlport_req_data     out  32  always 0
//   m_ctrlport_req_rd       out  1   one-cycle read strobe
//   m_ctrlport_req_wr       out  1   always 0
//   m_ctrlport_resp_ack     in   1   response valid
//   m_ctrlport_resp_data    in   32  read data
//   m_ctrlport_resp_status  in   2   CTRL_STS_* code
//   m_entry_tdata           out  32  entry word
//   m_entry_tindex          out  IW  entry index
//   m_entry_tlast           out  1   high with index NUM_ENTRIES-1
//   m_entry_tvalid          out  1   entry valid
//   m_entry_tready          in   1   downstream accept
//
// BEHAVIOUR
//   - Reset: state IDLE, index 0. All outputs 0 except byte_en = 4'hF.
//   - FSM states: IDLE, REQ, WAIT, OUT, DONE, ERROR.
//   - IDLE/DONE/ERROR + start:
//     clear done/error/err_*, set index 0 and timer 0, go to REQ.
//   - REQ: drive req_rd=1 for exactly this cycle, with addr = BASE_ADDR + index*ADDR_STRIDE.
//     Address arithmetic uses 20 bits; wrap-around is silently truncated.
//     Go to WAIT.
//   - WAIT: timer increments each cycle without ack.
//     - ack with status==CTRL_STS_OKAY: latch resp_data into tdata, go to OUT.
//     - ack with status!=OKAY: err_status=status, err_index=index, error=1, go to ERROR.
//     - timer==TIMEOUT_CYCLES-1 with no ack: err_timeout=1, err_status=0, error=1, go to ERROR.
//     - If ack and the timeout limit coincide, the ack wins.
//   - OUT: tvalid=1. tdata/tindex/tlast stay stable until tready.
//     On tvalid&&tready, tvalid drops next cycle.
//     - index==NUM_ENTRIES-1: done=1, go to DONE.
//     - Otherwise: index++, timer=0, go to REQ.
//   - busy=1 in REQ/WAIT/OUT. start is ignored while busy.
//   - ack outside WAIT (stale or late after a timeout) is discarded with no state change.
//   - ack in the first WAIT cycle is legal: 1-cycle read latency gives one entry per 3 cycles with tready=1.
//   - rst mid-sweep: returns to IDLE next cycle and clears sticky flags. A pending stream beat is dropped.
//   - The block never issues writes.
//
// STRUCTURE
//   - Use the CTRL_STS_* codes from ctrlport.vh.
//   - Add to rfdc_info_pkg:
//     - typedef rfdc_reader_err_t {timeout, status[1:0], index}
//     - DEFAULT_READER_TIMEOUT = 1024
//   - The FSM enum stays local to the module.
//   - Single flat module; no sub-module is warranted.
//
// TESTING
//   1. NUM_ENTRIES=4, BASE_ADDR=0x100, memory model with 1-cycle ack, tready=1.
//      Expect:
//      - rd at addrs 0x100/104/108/10C
//      - 4 beats with index 0..3, tlast on index 3
//      - done=1 twelve cycles after start
//   2. tready held low for 10 cycles on beat 1 -> tdata/tindex stable, no new rd issued until accept.
//   3. Memory returns CTRL_STS_CMDERR on entry 2 -> error=1, err_status=1, err_index=2,
//      only 2 beats emitted, busy=0.
//   4. TIMEOUT_CYCLES=8, no ack on entry 0 -> error=1, err_timeout=1 eight cycles after rd.
//      An ack on the 9th cycle is ignored.
//   5. Scenarios:
//      - start during a sweep -> ignored
//      - rst asserted in OUT -> all outputs return to reset values next cycle
//      - a following start sweeps cleanly from index 0

Source files
------------

// File: rtl/rfdc_info_pkg.sv
// Shared types and constants for the RFDC info memory reader.
package rfdc_info_pkg;
    // Ctrlport response status codes, identical to the CTRL_STS_* values in ctrlport.vh.
    localparam logic [1:0] CTRL_STS_OKAY    = 2'd0;
    localparam logic [1:0] CTRL_STS_CMDERR  = 2'd1;
    localparam logic [1:0] CTRL_STS_TSERR   = 2'd2;
    localparam logic [1:0] CTRL_STS_WARNING = 2'd3;

    localparam int DEFAULT_READER_TIMEOUT = 1024;
    localparam int READER_INDEX_MAX_W     = 16;

    typedef struct packed {
        logic                          timeout;
        logic [1:0]                    status;
        logic [READER_INDEX_MAX_W-1:0] index;
    } rfdc_reader_err_t;

    function automatic int reader_index_width(input int num_entries);
        return (num_entries > 1) ? $clog2(num_entries) : 1;
    endfunction
endpackage

// File: rtl/rfdc_info_reader.sv
// Ctrlport master that sweeps the read-only RFDC info memory and streams each
// entry with its index; stops on the first bad status or response timeout.
module rfdc_info_reader
    import rfdc_info_pkg::*;
#(
    parameter int          NUM_ENTRIES    = 16,
    parameter logic [19:0] BASE_ADDR      = 20'h0,
    parameter logic [19:0] ADDR_STRIDE    = 20'd4,
    parameter int          TIMEOUT_CYCLES = DEFAULT_READER_TIMEOUT,
    localparam int         IW             = reader_index_width(NUM_ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          err_timeout,
    output logic [1:0]    err_status,
    output logic [IW-1:0] err_index,
    output logic [2:0]    dbg_state,
    output logic [19:0]   m_ctrlport_req_addr,
    output logic [3:0]    m_ctrlport_req_byte_en,
    output logic [31:0]   m_ctrlport_req_data,
    output logic          m_ctrlport_req_rd,
    output logic          m_ctrlport_req_wr,
    input  logic          m_ctrlport_resp_ack,
    input  logic [31:0]   m_ctrlport_resp_data,
    input  logic [1:0]    m_ctrlport_resp_status,
    output logic [31:0]   m_entry_tdata,
    output logic [IW-1:0] m_entry_tindex,
    output logic          m_entry_tlast,
    output logic          m_entry_tvalid,
    input  logic          m_entry_tready
);
    localparam int            TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] LAST_INDEX = IW'(NUM_ENTRIES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ, ST_WAIT, ST_OUT, ST_DONE, ST_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    index_q;
    logic [TW-1:0]    timer_q;
    logic [31:0]      tdata_q;
    rfdc_reader_err_t err_q;
    logic             resp_ok;
    logic             is_last;
    logic             unused_err;

    assign resp_ok = (m_ctrlport_resp_status == CTRL_STS_OKAY);
    assign is_last = (index_q == LAST_INDEX);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_REQ;
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: begin
                // An ack arriving on the timeout cycle still counts as a response.
                if (m_ctrlport_resp_ack)      state_d = resp_ok ? ST_OUT : ST_ERROR;
                else if (timer_q == TIMER_MAX) state_d = ST_ERROR;
            end
            ST_OUT:  if (m_entry_tready) state_d = is_last ? ST_DONE : ST_REQ;
            default: state_d = ST_IDLE;
        endcase
    end

    // Stream handshake: a beat transfers on any cycle with m_entry_tvalid && m_entry_tready;
    // once tvalid rises, tvalid/tdata/tindex/tlast hold steady until that cycle.
    always_comb begin
        busy              = 1'b0;
        m_ctrlport_req_rd = 1'b0;
        m_entry_tvalid    = 1'b0;
        case (state_q)
            ST_REQ:  begin busy = 1'b1; m_ctrlport_req_rd = 1'b1; end
            ST_WAIT: busy = 1'b1;
            ST_OUT:  begin busy = 1'b1; m_entry_tvalid = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            index_q <= '0;
            timer_q <= '0;
            tdata_q <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
            err_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        done    <= 1'b0;
                        error   <= 1'b0;
                        err_q   <= '0;
                        index_q <= '0;
                        timer_q <= '0;
                    end
                end
                ST_WAIT: begin
                    if (m_ctrlport_resp_ack) begin
                        if (resp_ok) begin
                            tdata_q <= m_ctrlport_resp_data;
                        end else begin
                            error <= 1'b1;
                            err_q <= '{timeout: 1'b0, status: m_ctrlport_resp_status,
                                       index: READER_INDEX_MAX_W'(index_q)};
                        end
                    end else if (timer_q == TIMER_MAX) begin
                        error <= 1'b1;
                        err_q <= '{timeout: 1'b1, status: 2'b00,
                                   index: READER_INDEX_MAX_W'(index_q)};
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_OUT: begin
                    if (m_entry_tready) begin
                        if (is_last) begin
                            done <= 1'b1;
                        end else begin
                            index_q <= index_q + IW'(1);
                            timer_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Address is only presented with the strobe so the bus idles at zero.
    assign m_ctrlport_req_addr    = m_ctrlport_req_rd ? (BASE_ADDR + 20'(index_q) * ADDR_STRIDE) : 20'h0;
    assign m_ctrlport_req_byte_en = 4'hF;
    assign m_ctrlport_req_data    = 32'h0;
    assign m_ctrlport_req_wr      = 1'b0;

    assign m_entry_tdata  = tdata_q;
    assign m_entry_tindex = index_q;
    assign m_entry_tlast  = m_entry_tvalid && is_last;

    assign err_timeout = err_q.timeout;
    assign err_status  = err_q.status;
    assign err_index   = err_q.index[IW-1:0];
    // Upper index bits of the shared error record are always zero here.
    assign unused_err  = |err_q.index;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_rfdc_info_reader.sv
// Randomized self-checking bench for rfdc_info_reader against a sweep-level model.
module tb_rfdc_info_reader;
    import rfdc_info_pkg::*;

    localparam int N      = 4;
    localparam int BASE   = 'h100;
    localparam int STRIDE = 4;
    localparam int TOUT   = 8;
    localparam int IW     = 2;
    localparam int W      = 1 + IW + 32;
    localparam int OW     = 98 + 2 * IW;
    localparam logic [OW-1:0] RESET_VEC = {{(26 + IW){1'b0}}, 4'hF, {(68 + IW){1'b0}}};

    logic clk = 1'b0;
    logic rst, start;
    logic busy, done, error, err_timeout;
    logic [1:0] err_status;
    logic [IW-1:0] err_index;
    logic [2:0] dbg_state;
    logic [19:0] m_ctrlport_req_addr;
    logic [3:0] m_ctrlport_req_byte_en;
    logic [31:0] m_ctrlport_req_data;
    logic m_ctrlport_req_rd, m_ctrlport_req_wr;
    logic m_ctrlport_resp_ack;
    logic [31:0] m_ctrlport_resp_data;
    logic [1:0] m_ctrlport_resp_status;
    logic [31:0] m_entry_tdata;
    logic [IW-1:0] m_entry_tindex;
    logic m_entry_tlast, m_entry_tvalid, m_entry_tready;

    int n_checks = 0;
    int n_fails  = 0;
    int wr_seen  = 0;

    logic [31:0] mem [N];
    int          lat_cfg [N];
    logic [1:0]  sts_cfg [N];

    bit   rand_tready = 1'b0;
    logic tready_rand = 1'b1;
    logic tready_fixed = 1'b1;
    assign m_entry_tready = rand_tready ? tready_rand : tready_fixed;

    logic [W-1:0]  exp_q [$];
    logic [W-1:0]  got_q [$];
    logic [19:0]   exp_addr_q [$];
    logic [19:0]   rd_q [$];
    logic          exp_done, exp_error, exp_to;
    logic [1:0]    exp_sts;
    logic [IW-1:0] exp_idx;

    rfdc_info_reader #(
        .NUM_ENTRIES(N), .BASE_ADDR(20'h100), .ADDR_STRIDE(20'd4), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .err_timeout(err_timeout), .err_status(err_status), .err_index(err_index),
        .dbg_state(dbg_state),
        .m_ctrlport_req_addr(m_ctrlport_req_addr), .m_ctrlport_req_byte_en(m_ctrlport_req_byte_en),
        .m_ctrlport_req_data(m_ctrlport_req_data), .m_ctrlport_req_rd(m_ctrlport_req_rd),
        .m_ctrlport_req_wr(m_ctrlport_req_wr), .m_ctrlport_resp_ack(m_ctrlport_resp_ack),
        .m_ctrlport_resp_data(m_ctrlport_resp_data), .m_ctrlport_resp_status(m_ctrlport_resp_status),
        .m_entry_tdata(m_entry_tdata), .m_entry_tindex(m_entry_tindex),
        .m_entry_tlast(m_entry_tlast), .m_entry_tvalid(m_entry_tvalid),
        .m_entry_tready(m_entry_tready)
    );

    // Clock and global time limit
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected summary");
        $fatal(1, "watchdog");
    end

    // Bus monitor: records read addresses and accepted beats
    always @(negedge clk) begin
        if (!rst && m_ctrlport_req_rd) rd_q.push_back(m_ctrlport_req_addr);
        if (m_entry_tvalid && m_entry_tready) got_q.push_back({m_entry_tlast, m_entry_tindex, m_entry_tdata});
        if (m_ctrlport_req_wr) wr_seen++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_tready) tready_rand = 1'($urandom_range(0, 1));
        end
    end

    // Memory responder: acks lat_cfg[i] cycles into the wait, with sts_cfg[i]
    initial begin
        int r_idx;
        m_ctrlport_resp_ack = 1'b0;
        m_ctrlport_resp_data = '0;
        m_ctrlport_resp_status = '0;
        forever begin
            @(negedge clk);
            if (m_ctrlport_req_rd && !rst) begin
                r_idx = (int'(m_ctrlport_req_addr) - BASE) / STRIDE;
                if (r_idx >= 0 && r_idx < N) begin
                    @(posedge clk);
                    repeat (lat_cfg[r_idx]) @(posedge clk);
                    #1;
                    m_ctrlport_resp_ack = 1'b1;
                    m_ctrlport_resp_data = (sts_cfg[r_idx] == CTRL_STS_OKAY) ? mem[r_idx] : 32'hDEAD_BEEF;
                    m_ctrlport_resp_status = sts_cfg[r_idx];
                    @(posedge clk);
                    #1;
                    m_ctrlport_resp_ack = 1'b0;
                    m_ctrlport_resp_data = '0;
                    m_ctrlport_resp_status = '0;
                end
            end
        end
    end

    function automatic logic [OW-1:0] outputs_vec();
        return {busy, done, error, err_timeout, err_status, err_index, m_ctrlport_req_addr,
                m_ctrlport_req_byte_en, m_ctrlport_req_data, m_ctrlport_req_rd, m_ctrlport_req_wr,
                m_entry_tdata, m_entry_tindex, m_entry_tlast, m_entry_tvalid};
    endfunction

    // Reference model: what a whole sweep should produce given the memory setup
    task automatic build_model();
        logic [IW-1:0] ix;
        exp_q.delete();
        exp_addr_q.delete();
        exp_done = 1'b0; exp_error = 1'b0; exp_to = 1'b0; exp_sts = '0; exp_idx = '0;
        for (int i = 0; i < N; i++) begin
            ix = IW'(i);
            exp_addr_q.push_back(20'(BASE + i * STRIDE));
            if (lat_cfg[i] >= TOUT) begin
                exp_error = 1'b1; exp_to = 1'b1; exp_idx = ix;
                return;
            end
            if (sts_cfg[i] != CTRL_STS_OKAY) begin
                exp_error = 1'b1; exp_sts = sts_cfg[i]; exp_idx = ix;
                return;
            end
            exp_q.push_back({(i == N - 1), ix, mem[i]});
        end
        exp_done = 1'b1;
    endtask

    // Driver tasks
    task automatic new_sweep_cfg(input int lat);
        for (int i = 0; i < N; i++) begin
            mem[i] = $urandom;
            lat_cfg[i] = lat;
            sts_cfg[i] = CTRL_STS_OKAY;
        end
    endtask

    task automatic pulse_start();
        rd_q.delete();
        got_q.delete();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!busy && (done || error)) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_sweep(output bit timed_out);
        pulse_start();
        wait_idle(timed_out);
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (outputs_vec() !== RESET_VEC) begin
            n_fails++;
            $display("FAIL reset_outputs: got %h expected %h", outputs_vec(), RESET_VEC);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (outputs_vec() !== RESET_VEC) begin
            n_fails++;
            $display("FAIL idle_after_reset: got %h expected %h", outputs_vec(), RESET_VEC);
        end
    endtask

    task automatic test_basic();
        int cyc;
        int busy_low;
        new_sweep_cfg(0);
        build_model();
        pulse_start();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fails++;
            $display("FAIL basic_start_clears: got done=%b busy=%b expected done=0 busy=1", done, busy);
        end
        cyc = 0;
        busy_low = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done !== 1'b1 && busy !== 1'b1) busy_low++;
        end
        n_checks++;
        if (cyc != 3 * N) begin
            n_fails++;
            $display("FAIL basic_done_latency: got %0d cycles expected %0d", cyc, 3 * N);
        end
        n_checks++;
        if (busy_low != 0) begin
            n_fails++;
            $display("FAIL basic_busy: got %0d idle cycles mid-sweep expected 0", busy_low);
        end
        n_checks++;
        if (rd_q.size() != exp_addr_q.size() || got_q.size() != exp_q.size()) begin
            n_fails++;
            $display("FAIL basic_counts: got rd=%0d beats=%0d expected rd=%0d beats=%0d",
                     rd_q.size(), got_q.size(), exp_addr_q.size(), exp_q.size());
        end else begin
            foreach (exp_addr_q[k]) begin
                n_checks++;
                if (rd_q[k] !== exp_addr_q[k]) begin
                    n_fails++;
                    $display("FAIL basic_rd_addr[%0d]: got %h expected %h", k, rd_q[k], exp_addr_q[k]);
                end
            end
            foreach (exp_q[k]) begin
                n_checks++;
                if (got_q[k] !== exp_q[k]) begin
                    n_fails++;
                    $display("FAIL basic_beat[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit to;
        new_sweep_cfg(0);
        build_model();
        tready_fixed = 1'b0;
        pulse_start();
        cyc = 0;
        while (m_entry_tvalid !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        tready_fixed = 1'b1;
        @(posedge clk);
        #1 tready_fixed = 1'b0;
        cyc = 0;
        while (m_entry_tvalid !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if ({m_entry_tvalid, m_entry_tindex, m_entry_tdata} !== {1'b1, IW'(1), mem[1]}) begin
                n_fails++;
                $display("FAIL stall_hold[%0d]: got v=%b idx=%0d data=%h expected v=1 idx=1 data=%h",
                         k, m_entry_tvalid, m_entry_tindex, m_entry_tdata, mem[1]);
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (rd_q.size() != 2 || got_q.size() != 1) begin
            n_fails++;
            $display("FAIL stall_no_new_rd: got rd=%0d beats=%0d expected rd=2 beats=1", rd_q.size(), got_q.size());
        end
        tready_fixed = 1'b1;
        wait_idle(to);
        n_checks++;
        if (to || got_q.size() != exp_q.size() || done !== 1'b1) begin
            n_fails++;
            $display("FAIL stall_finish: got timeout=%0d beats=%0d done=%b expected 0/%0d/1",
                     to, got_q.size(), done, exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                n_checks++;
                if (got_q[k] !== exp_q[k]) begin
                    n_fails++;
                    $display("FAIL stall_beat[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_cmderr();
        bit to;
        new_sweep_cfg(0);
        sts_cfg[2] = CTRL_STS_CMDERR;
        run_sweep(to);
        n_checks++;
        if (to || {error, err_timeout, err_status, err_index, busy, done} !== {1'b1, 1'b0, CTRL_STS_CMDERR, IW'(2), 1'b0, 1'b0}) begin
            n_fails++;
            $display("FAIL cmderr_flags: got to=%0d err=%b tmo=%b sts=%0d idx=%0d busy=%b done=%b expected 0 1 0 1 2 0 0",
                     to, error, err_timeout, err_status, err_index, busy, done);
        end
        n_checks++;
        if (got_q.size() != 2 || rd_q.size() != 3) begin
            n_fails++;
            $display("FAIL cmderr_counts: got beats=%0d rd=%0d expected beats=2 rd=3", got_q.size(), rd_q.size());
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_timeout();
        int cyc;
        int ack_seen;
        new_sweep_cfg(0);
        lat_cfg[0] = TOUT;
        build_model();
        pulse_start();
        cyc = 0;
        while (error !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        // The read cycle plus TOUT wait cycles elapse before the fault registers.
        n_checks++;
        if (cyc != TOUT + 1) begin
            n_fails++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d", cyc, TOUT + 1);
        end
        n_checks++;
        if ({error, err_timeout, err_status, err_index, busy, done} !== {exp_error, exp_to, exp_sts, exp_idx, 1'b0, 1'b0}) begin
            n_fails++;
            $display("FAIL timeout_flags: got err=%b tmo=%b sts=%0d idx=%0d busy=%b done=%b expected 1 1 0 0 0 0",
                     error, err_timeout, err_status, err_index, busy, done);
        end
        ack_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (m_ctrlport_resp_ack) ack_seen++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (ack_seen != 1 || {error, err_timeout, err_status, err_index, m_entry_tvalid, busy} !== {1'b1, 1'b1, 2'b00, IW'(0), 1'b0, 1'b0}
            || got_q.size() != 0 || rd_q.size() != 1) begin
            n_fails++;
            $display("FAIL late_ack_ignored: got acks=%0d err=%b tmo=%b sts=%0d v=%b busy=%b beats=%0d rd=%0d expected 1 1 1 0 0 0 0 1",
                     ack_seen, error, err_timeout, err_status, m_entry_tvalid, busy, got_q.size(), rd_q.size());
        end
    endtask

    task automatic test_ack_wins();
        bit to;
        new_sweep_cfg(TOUT - 1);
        build_model();
        run_sweep(to);
        n_checks++;
        if (to || done !== 1'b1 || error !== 1'b0 || got_q.size() != N) begin
            n_fails++;
            $display("FAIL ack_at_limit: got to=%0d done=%b err=%b beats=%0d expected 0 1 0 %0d",
                     to, done, error, got_q.size(), N);
        end else begin
            foreach (exp_q[k]) begin
                n_checks++;
                if (got_q[k] !== exp_q[k]) begin
                    n_fails++;
                    $display("FAIL ack_at_limit_beat[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_start_during_sweep();
        bit to;
        new_sweep_cfg(2);
        build_model();
        pulse_start();
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fails++;
            $display("FAIL busy_before_restart: got %b expected 1", busy);
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(to);
        n_checks++;
        if (to || done !== 1'b1 || rd_q.size() != N || got_q.size() != N) begin
            n_fails++;
            $display("FAIL restart_ignored: got to=%0d done=%b rd=%0d beats=%0d expected 0 1 %0d %0d",
                     to, done, rd_q.size(), got_q.size(), N, N);
        end else begin
            foreach (exp_q[k]) begin
                n_checks++;
                if (got_q[k] !== exp_q[k] || rd_q[k] !== exp_addr_q[k]) begin
                    n_fails++;
                    $display("FAIL restart_beat[%0d]: got %h @%h expected %h @%h", k, got_q[k], rd_q[k], exp_q[k], exp_addr_q[k]);
                end
            end
        end
    endtask

    task automatic test_rst_in_out();
        int cyc;
        bit to;
        new_sweep_cfg(0);
        tready_fixed = 1'b0;
        pulse_start();
        cyc = 0;
        while (m_entry_tvalid !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        n_checks++;
        if (m_entry_tvalid !== 1'b1) begin
            n_fails++;
            $display("FAIL reach_out: got tvalid=%b expected 1", m_entry_tvalid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (outputs_vec() !== RESET_VEC) begin
            n_fails++;
            $display("FAIL rst_in_out: got %h expected %h", outputs_vec(), RESET_VEC);
        end
        rst = 1'b0;
        tready_fixed = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (got_q.size() != 0) begin
            n_fails++;
            $display("FAIL rst_beat_dropped: got %0d beats expected 0", got_q.size());
        end
        new_sweep_cfg(1);
        build_model();
        run_sweep(to);
        n_checks++;
        if (to || done !== 1'b1 || rd_q.size() != N || got_q.size() != N) begin
            n_fails++;
            $display("FAIL post_rst_sweep: got to=%0d done=%b rd=%0d beats=%0d expected 0 1 %0d %0d",
                     to, done, rd_q.size(), got_q.size(), N, N);
        end else begin
            foreach (exp_q[k]) begin
                n_checks++;
                if (got_q[k] !== exp_q[k] || rd_q[k] !== exp_addr_q[k]) begin
                    n_fails++;
                    $display("FAIL post_rst_beat[%0d]: got %h @%h expected %h @%h", k, got_q[k], rd_q[k], exp_q[k], exp_addr_q[k]);
                end
            end
        end
    endtask

    task automatic test_random_sweeps();
        bit to;
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < N; i++) begin
                mem[i] = $urandom;
                lat_cfg[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TOUT, TOUT + 1)) : int'($urandom_range(0, TOUT - 1));
                sts_cfg[i] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : CTRL_STS_OKAY;
            end
            build_model();
            rand_tready = 1'b1;
            run_sweep(to);
            rand_tready = 1'b0;
            n_checks++;
            if (to || {done, error, err_timeout, err_status, err_index} !== {exp_done, exp_error, exp_to, exp_sts, exp_idx}) begin
                n_fails++;
                $display("FAIL rand%0d_status: got to=%0d done=%b err=%b tmo=%b sts=%0d idx=%0d expected 0 %b %b %b %0d %0d",
                         it, to, done, error, err_timeout, err_status, err_index, exp_done, exp_error, exp_to, exp_sts, exp_idx);
            end
            n_checks++;
            if (rd_q.size() != exp_addr_q.size() || got_q.size() != exp_q.size()) begin
                n_fails++;
                $display("FAIL rand%0d_counts: got rd=%0d beats=%0d expected rd=%0d beats=%0d",
                         it, rd_q.size(), got_q.size(), exp_addr_q.size(), exp_q.size());
            end else begin
                foreach (exp_addr_q[k]) begin
                    n_checks++;
                    if (rd_q[k] !== exp_addr_q[k]) begin
                        n_fails++;
                        $display("FAIL rand%0d_rd[%0d]: got %h expected %h", it, k, rd_q[k], exp_addr_q[k]);
                    end
                end
                foreach (exp_q[k]) begin
                    n_checks++;
                    if (got_q[k] !== exp_q[k]) begin
                        n_fails++;
                        $display("FAIL rand%0d_beat[%0d]: got %h expected %h", it, k, got_q[k], exp_q[k]);
                    end
                end
            end
            repeat (15) @(posedge clk);
        end
        n_checks++;
        if (wr_seen != 0 || m_ctrlport_req_byte_en !== 4'hF || m_ctrlport_req_data !== 32'h0) begin
            n_fails++;
            $display("FAIL no_writes: got wr=%0d be=%h data=%h expected 0 f 0", wr_seen, m_ctrlport_req_byte_en, m_ctrlport_req_data);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            mem[i] = '0;
            lat_cfg[i] = 0;
            sts_cfg[i] = CTRL_STS_OKAY;
        end
        test_reset();
        test_basic();
        test_basic();
        test_backpressure();
        test_cmderr();
        test_timeout();
        test_ack_wins();
        test_start_during_sweep();
        test_rst_in_out();
        test_random_sweeps();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
